// File: rtl/prom_fetch.sv
// prom_fetch: fetch stage that reads one instruction from a nibble-wide
// external program memory over a req/ack bus and hands it to the core.
//
// Ports:
//   CLK, RST       clock; synchronous active-high reset
//   PC             core program counter, sampled in ADDR
//   INSTR          assembled instruction, updated on entry to EXEC
//   CORE_EN        one-cycle execute enable (EXEC state)
//   MEM_REQ        read request, high throughout FETCH
//   MEM_ADDR       {pc_latched, beat} nibble address
//   MEM_ACK        acknowledge, MEM_DATA valid in the same cycle
//   MEM_DATA       read data beat
//
// Optional feature macro: FETCH_REUSE_EN
//   When defined, a tag/valid pair remembers the last fetched PC so that
//   re-executing the same PC skips the memory read entirely.
module prom_fetch #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8,
  parameter int BEAT_W  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [PC_W-1:0]      PC,
  output logic [INSTR_W-1:0]   INSTR,
  output logic                 CORE_EN,
  output logic                 MEM_REQ,
  output logic [PC_W+$clog2(INSTR_W/BEAT_W)-1:0] MEM_ADDR,
  input  logic                 MEM_ACK,
  input  logic [BEAT_W-1:0]    MEM_DATA
);

  localparam int BEATS = INSTR_W / BEAT_W;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    FETCH,
    EXEC
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [INSTR_W-1:0]  stg_q, stg_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                hit;

`ifdef FETCH_REUSE_EN
  logic [PC_W-1:0]     tag_q, tag_d;
  logic                vld_q, vld_d;

  assign hit = vld_q && (PC == tag_q);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    beat_d  = beat_q;
    stg_d   = stg_q;
    instr_d = instr_q;
    MEM_REQ = 1'b0;
    CORE_EN = 1'b0;
`ifdef FETCH_REUSE_EN
    tag_d   = tag_q;
    vld_d   = vld_q;
`endif
    unique case (state_q)
      IDLE: state_d = ADDR;
      ADDR: begin
        pc_d    = PC;
        beat_d  = '0;
        state_d = hit ? EXEC : FETCH;
      end
      FETCH: begin
        MEM_REQ = 1'b1;
        if (MEM_ACK) begin
          for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BW'(i))
              stg_d[i*BEAT_W +: BEAT_W] = MEM_DATA;
          end
          if (beat_q == LAST) begin
            // Final beat is merged combinationally so INSTR
            // lands on the same edge that enters EXEC.
            instr_d = stg_d;
            state_d = EXEC;
`ifdef FETCH_REUSE_EN
            tag_d   = pc_q;
            vld_d   = 1'b1;
`endif
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      EXEC: begin
        CORE_EN = 1'b1;
        state_d = ADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= '0;
      beat_q  <= '0;
      stg_q   <= '0;
      instr_q <= '0;
`ifdef FETCH_REUSE_EN
      tag_q   <= '0;
      vld_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      beat_q  <= beat_d;
      stg_q   <= stg_d;
      instr_q <= instr_d;
`ifdef FETCH_REUSE_EN
      tag_q   <= tag_d;
      vld_q   <= vld_d;
`endif
    end
  end

  assign INSTR = instr_q;

  generate
    if (BEATS > 1) begin : g_beat
      assign MEM_ADDR = {pc_q, beat_q};
    end else begin : g_nobeat
      assign MEM_ADDR = pc_q;
    end
  endgenerate

endmodule

// File: tb/tb_prom_fetch.sv
// tb_prom_fetch: directed bench for prom_fetch with a memory responder
// and an instruction scoreboard checked on every CORE_EN pulse.
module tb_prom_fetch;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] PC = 8'h00;
  logic [7:0] INSTR;
  logic       CORE_EN;
  logic       MEM_REQ;
  logic [8:0] MEM_ADDR;
  logic       MEM_ACK = 1'b0;
  logic [3:0] MEM_DATA = 4'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int t = 0;

  logic [3:0] mem [512];
  logic [7:0] exp_q [$];
  logic [7:0] pcs [$];
  logic       prev_en = 1'b0;
  logic       rst_prev = 1'b0;
  logic [7:0] last_instr = 8'h00;

`ifdef FETCH_REUSE_EN
  localparam int GAP = 2;
  localparam int EXPB = 2;
`else
  localparam int GAP = 4;
  localparam int EXPB = 8;
`endif

  prom_fetch dut (
    .CLK(CLK),
    .RST(RST),
    .PC(PC),
    .INSTR(INSTR),
    .CORE_EN(CORE_EN),
    .MEM_REQ(MEM_REQ),
    .MEM_ADDR(MEM_ADDR),
    .MEM_ACK(MEM_ACK),
    .MEM_DATA(MEM_DATA)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ins(input logic [7:0] p);
    return {mem[{p, 1'b1}], mem[{p, 1'b0}]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of memory inputs, advance to the next negedge,
  // then score CORE_EN / INSTR for the new cycle.
  task automatic step(input bit ack, input bit spur);
    logic [7:0] e;
    MEM_ACK  = spur | (ack & MEM_REQ);
    MEM_DATA = MEM_REQ ? mem[MEM_ADDR] :
               (spur ? 4'hF : 4'($urandom));
    if (MEM_REQ && MEM_ACK) beats++;
    rst_prev = RST;
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    if (CORE_EN) begin
      chk("en_gap", 32'(prev_en), 0);
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_instr", 32'(INSTR), 32'(e));
      end
      if (pcs.size() > 0) PC = pcs.pop_front();
      exp_q.push_back(ins(PC));
    end else if (!rst_prev) begin
      chk("instr_hold", 32'(INSTR), 32'(last_instr));
    end
    prev_en    = CORE_EN;
    last_instr = INSTR;
  endtask

  task automatic wait_en(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step(1'b1, 1'b0);
      got = CORE_EN;
    end
    chk("en_timeout", 32'(got), 1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 4'($urandom);
    mem[9'h000] = 4'h1;
    mem[9'h001] = 4'h7;
    mem[9'h00A] = 4'h3;
    mem[9'h00B] = 4'hA;
    mem[9'h00C] = 4'h5;
    mem[9'h00D] = 4'hC;
    mem[9'h020] = 4'hE;
    mem[9'h021] = 4'h2;
    pcs = '{8'h05, 8'h06, 8'h05, 8'h06, 8'h05,
            8'h10, 8'h10, 8'h10, 8'h10};

    // reset held with random bus noise
    RST = 1'b1;
    repeat (3) begin
      MEM_ACK  = 1'($urandom);
      MEM_DATA = 4'($urandom);
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_instr", 32'(INSTR), 0);
      chk("rst_en", 32'(CORE_EN), 0);
      chk("rst_req", 32'(MEM_REQ), 0);
      chk("rst_addr", 32'(MEM_ADDR), 0);
    end

    RST     = 1'b0;
    MEM_ACK = 1'b0;
    exp_q.delete();
    exp_q.push_back(ins(PC));
    last_instr = INSTR;
    prev_en    = 1'b0;
    step(1'b1, 1'b0);
    chk("boot_req_addr_state", 32'(MEM_REQ), 0);
    step(1'b1, 1'b0);
    chk("boot_req", 32'(MEM_REQ), 1);
    chk("boot_addr", 32'(MEM_ADDR), 0);
    wait_en(10);

    // zero-wait fetch of PC 0x05
    step(1'b1, 1'b0);
    chk("zw_addr_state", 32'(MEM_REQ), 0);
    step(1'b1, 1'b0);
    chk("zw_req", 32'(MEM_REQ), 1);
    chk("zw_a0", 32'(MEM_ADDR), 'h0A);
    step(1'b1, 1'b0);
    chk("zw_a1", 32'(MEM_ADDR), 'h0B);
    step(1'b1, 1'b0);
    chk("zw_en", 32'(CORE_EN), 1);
    chk("zw_instr", 32'(INSTR), 'hA3);
    t = cyc;
    wait_en(10);
    chk("zw_period", cyc - t, 4);
    t = cyc;

    // three wait cycles on beat 1 of PC 0x05
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("ws_a0", 32'(MEM_ADDR), 'h0A);
    step(1'b1, 1'b0);
    chk("ws_a1", 32'(MEM_ADDR), 'h0B);
    repeat (3) begin
      step(1'b0, 1'b0);
      chk("ws_hold_addr", 32'(MEM_ADDR), 'h0B);
      chk("ws_req", 32'(MEM_REQ), 1);
      chk("ws_old_instr", 32'(INSTR), 'hC5);
    end
    step(1'b1, 1'b0);
    chk("ws_en", 32'(CORE_EN), 1);
    chk("ws_latency", cyc - t, 7);

    // reset after beat 0 of PC 0x06 is acknowledged
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("mr_a0", 32'(MEM_ADDR), 'h0C);
    step(1'b1, 1'b0);
    chk("mr_a1", 32'(MEM_ADDR), 'h0D);
    RST = 1'b1;
    step(1'b0, 1'b0);
    chk("mr_req", 32'(MEM_REQ), 0);
    chk("mr_instr", 32'(INSTR), 0);
    chk("mr_en", 32'(CORE_EN), 0);
    RST = 1'b0;
    mem[9'h00C] = 4'h9;
    exp_q.delete();
    exp_q.push_back(ins(PC));
    prev_en = 1'b0;
    step(1'b1, 1'b0);
    chk("mr_addr_state", 32'(MEM_REQ), 0);
    step(1'b1, 1'b0);
    chk("mr_refetch_a0", 32'(MEM_ADDR), 'h0C);
    chk("mr_refetch_req", 32'(MEM_REQ), 1);
    wait_en(10);
    chk("mr_new_instr", 32'(INSTR), 'hC9);

    // spurious ACK with 0xF during EXEC and ADDR
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("sp_beat0", 32'(MEM_ADDR), 'h0A);
    chk("sp_instr", 32'(INSTR), 'hC9);
    wait_en(10);

    // PC held at 0x10 for four executions
    beats = 0;
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_en(12);
      if (k > 0) chk("ru_gap", cyc - t, GAP);
      t = cyc;
    end
    chk("ru_beats", beats, EXPB);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/prom_fetch.md
# prom_fetch

Instruction fetch stage between the 4-bit core and a pin-limited, nibble-wide external program memory. It takes the core's `PC`, reads the instruction over a request/acknowledge bus in `INSTR_W/BEAT_W` beats and assembles it. It then presents a stable `INSTR` and pulses `CORE_EN` for one cycle, so the core executes exactly one instruction per completed fetch.

## Interface
- `PC_W`, 8: program counter width (matches core PC length)
- `INSTR_W`, 8: instruction width (matches core instruction length)
- `BEAT_W`, 4: external memory data width; `INSTR_W` must be an integer multiple, `BEATS = INSTR_W/BEAT_W >= 1`

Ports:
- `CLK`  in  1  clock
- `RST`  in  1  reset; synchronous, active-high
- `PC`  in  PC_W  core program counter; changes only on the edge ending a `CORE_EN` cycle
- `INSTR`  out  INSTR_W  assembled instruction to the core
- `CORE_EN`  out  1  one-cycle execute enable to the core
- `MEM_REQ`  out  1  memory read request
- `MEM_ADDR`  out  PC_W+clog2(BEATS)  nibble address `{pc_latched, beat}`; beat field is absent when `BEATS=1`
- `MEM_ACK`  in  1  memory acknowledge; `MEM_DATA` is valid in the same cycle
- `MEM_DATA`  in  BEAT_W  read data

## Operation
- FSM states: IDLE, ADDR, FETCH, EXEC.
- **IDLE** (reset state) -> ADDR unconditionally.
- **ADDR**: latch `PC` into `pc_latched` and clear `beat` to 0, then go to FETCH. When `FETCH_REUSE_EN` is defined and hits, go to EXEC instead (see Configuration).
- **FETCH**:
  - `MEM_REQ=1`; `MEM_ADDR={pc_latched, beat}` is held stable until `MEM_ACK` is sampled high.
  - On ACK, write `MEM_DATA` into staging bits `[beat*BEAT_W +: BEAT_W]`. Beat 0 is the least significant nibble.
  - If `beat < BEATS-1`: increment `beat` and stay in FETCH. `MEM_REQ` stays high and the address advances on the next cycle.
  - If `beat == BEATS-1`: load `INSTR` from the staging register with this beat's data merged in, then go to EXEC.
- **EXEC**: `CORE_EN=1`, `MEM_REQ=0`, then go to ADDR.
- `INSTR` changes only on the edge entering EXEC. It holds the previous instruction throughout a fetch.
- `MEM_ACK` is ignored in every state other than FETCH.

## Timing
- Reset values: `INSTR=0`, `CORE_EN=0`, `MEM_REQ=0`, `MEM_ADDR=0`, state IDLE, `beat=0`, staging register 0, reuse tag invalid.
- A reset asserted in any state, including mid-fetch, takes effect on that edge: `MEM_REQ` drops in the next cycle and partial staging data is discarded.
- First `MEM_REQ` appears 2 cycles after reset deasserts (IDLE, then ADDR).
- Zero-wait memory (`MEM_ACK` high whenever `MEM_REQ` is high): one instruction every `BEATS+2` cycles, i.e. 4 cycles for the defaults.
- Each wait cycle on any beat adds exactly 1 cycle. There is no timeout.
- `CORE_EN` is never high on two consecutive cycles.
- `PC` is sampled only in ADDR, which is the cycle after EXEC, when the core's updated PC is already stable.

## Configuration
- Macro: `FETCH_REUSE_EN`.
- **Defined**:
  - The block keeps a tag register (the `pc_latched` value of the last completed fetch) and a valid bit.
  - In ADDR, if the valid bit is set and `PC` equals the tag, skip FETCH and go directly to EXEC. `INSTR` is unchanged and there is no memory traffic, so a self-loop or halt costs 2 cycles per instruction.
  - Reset clears the valid bit. Every completed fetch sets the valid bit and loads the tag.
- **Undefined**: every instruction is fetched from memory, and no tag or valid hardware exists.

## Test plan
- **Reset**: hold `RST` high for 3 cycles with random `MEM_ACK`/`MEM_DATA` -> all outputs 0 throughout. After release, `MEM_REQ` rises on the 3rd cycle with `MEM_ADDR=0`.
- **Zero-wait fetch**: `PC=0x05`, memory nibbles at 0x0A=0x3 and 0x0B=0xA -> addresses 0x0A then 0x0B on consecutive cycles. `INSTR=0xA3` with `CORE_EN` high exactly one cycle later, and a 4-cycle period.
- **Wait states**: `MEM_ACK` held low for 3 cycles on beat 1 -> `MEM_ADDR` holds 0x0B and `INSTR` keeps its old value. `CORE_EN` arrives 3 cycles later than in the zero-wait case.
- **Reset mid-fetch**: assert `RST` for one cycle after beat 0 is acknowledged -> `MEM_REQ` is 0 the next cycle and `INSTR=0`. The refetch starts at beat 0, and the staging nibble is not reused.
- **Spurious ACK**: pulse `MEM_ACK` with `MEM_DATA=0xF` during EXEC and ADDR -> `INSTR` and `beat` are unaffected.
- **Reuse**: `PC` held at 0x10 for 4 `CORE_EN` cycles.
  - With `FETCH_REUSE_EN`: one memory fetch, then `CORE_EN` every 2 cycles with `MEM_REQ=0`.
  - Without it: 4 full fetches.
